// File: rtl/synapse_sequencer.sv
// rtl/synapse_sequencer.sv - frame spike mask to ascending address token sequencer (optional SYNSEQ_STATS_EN adds oTokCnt)
module synapse_sequencer #(
  parameter int NA   = 4,
  parameter     TYPE = "rc",
  localparam int SW  = (TYPE == "rc") ? 2 : 1,
  localparam int AW  = $clog2(NA),
  localparam int TW  = 2 + SW + AW
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iValid_ST,
  output logic             oReady_ST,
  input  logic [SW+NA-1:0] iData_ST,
  output logic             oValid_AS,
  input  logic             iReady_AS,
  output logic [TW-1:0]    oData_AS,
  output logic             oBusy
`ifdef SYNSEQ_STATS_EN
  ,
  output logic [AW:0]      oTokCnt
`endif
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state;
  logic [NA-1:0] mask_r;
  logic [SW-1:0] sub_r;
  logic [TW-1:0] tok_r;
  logic          ready_r;

  logic          start_hs;
  logic          tok_hs;
  logic [NA-1:0] addr_oh;
  logic [NA-1:0] mask_clr;

  // Build the token for a remaining mask: lowest set bit first, null token when empty.
  function automatic logic [TW-1:0] make_token(input logic [NA-1:0] m, input logic [SW-1:0] s);
    logic [AW-1:0] a;
    logic          leap;
    logic          lst;
    a = '0;
    for (int i = NA - 1; i >= 0; i--) begin
      if (m[i]) a = AW'(i);
    end
    leap = (m == '0);
    lst  = leap || ((m & (m - NA'(1))) == '0);
    return {leap, lst, s, a};
  endfunction

  assign start_hs  = (state == IDLE) && ready_r && iValid_ST;
  assign tok_hs    = (state == RUN) && iReady_AS;

  assign oReady_ST = ready_r;
  assign oValid_AS = (state == RUN);
  assign oBusy     = (state == RUN);
  assign oData_AS  = tok_r;

  // Mask with the currently presented address retired.
  always_comb begin
    addr_oh                 = '0;
    addr_oh[tok_r[AW-1:0]]  = 1'b1;
    mask_clr                = mask_r & ~addr_oh;
  end

  // Frame FSM: capture on start, advance one token per accepted handshake.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state   <= IDLE;
      mask_r  <= '0;
      sub_r   <= '0;
      tok_r   <= '0;
      ready_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready_r <= 1'b1;
          if (start_hs) begin
            mask_r  <= iData_ST[NA-1:0];
            sub_r   <= iData_ST[SW+NA-1:NA];
            tok_r   <= make_token(iData_ST[NA-1:0], iData_ST[SW+NA-1:NA]);
            ready_r <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          if (tok_hs) begin
            mask_r <= mask_clr;
            if (tok_r[TW-2]) begin
              state   <= IDLE;
              ready_r <= 1'b1;
            end else begin
              tok_r <= make_token(mask_clr, sub_r);
            end
          end
        end
        default: begin
          state   <= IDLE;
          ready_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef SYNSEQ_STATS_EN
  logic [AW:0] tok_cnt;

  assign oTokCnt = tok_cnt;

  // Per-frame accepted token count, null token included.
  always_ff @(posedge iCLK) begin
    if (iRST || start_hs) begin
      tok_cnt <= '0;
    end else if (tok_hs) begin
      tok_cnt <= tok_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_synapse_sequencer.sv
// tb/tb_synapse_sequencer.sv - directed self-checking bench for synapse_sequencer
module tb_synapse_sequencer;

  localparam int NA = 4;
  localparam int SW = 2;
  localparam int AW = 2;
  localparam int TW = 2 + SW + AW;

  logic             iCLK;
  logic             iRST;
  logic             iValid_ST;
  logic             oReady_ST;
  logic [SW+NA-1:0] iData_ST;
  logic             oValid_AS;
  logic             iReady_AS;
  logic [TW-1:0]    oData_AS;
  logic             oBusy;
`ifdef SYNSEQ_STATS_EN
  logic [AW:0]      oTokCnt;
`endif

  int n_pass  = 0;
  int n_total = 0;

  synapse_sequencer #(.NA(NA), .TYPE("rc")) dut (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .iValid_ST (iValid_ST),
    .oReady_ST (oReady_ST),
    .iData_ST  (iData_ST),
    .oValid_AS (oValid_AS),
    .iReady_AS (iReady_AS),
    .oData_AS  (oData_AS),
    .oBusy     (oBusy)
`ifdef SYNSEQ_STATS_EN
    ,
    .oTokCnt   (oTokCnt)
`endif
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Advance one clock; outputs are sampled and inputs changed 1 time unit after the edge.
  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic test_reset();
    iRST = 1'b1; iValid_ST = 1'b0; iReady_AS = 1'b0; iData_ST = '0;
    repeat (2) step();
    n_total++; if (oValid_AS !== 1'b0) $display("FAIL rst_valid: got %b want 0", oValid_AS); else n_pass++;
    n_total++; if (oBusy !== 1'b0) $display("FAIL rst_busy: got %b want 0", oBusy); else n_pass++;
    n_total++; if (oReady_ST !== 1'b0) $display("FAIL rst_ready: got %b want 0", oReady_ST); else n_pass++;
    iRST = 1'b0;
    step();
    n_total++; if (oReady_ST !== 1'b1) $display("FAIL rst_ready_rise: got %b want 1", oReady_ST); else n_pass++;
    n_total++; if (oBusy !== 1'b0) $display("FAIL rst_busy_after: got %b want 0", oBusy); else n_pass++;
  endtask

  task automatic test_basic();
    logic [TW-1:0] exp_tok [3];
    exp_tok[0] = 6'b00_10_00;
    exp_tok[1] = 6'b00_10_01;
    exp_tok[2] = 6'b01_10_11;
    iValid_ST = 1'b1; iData_ST = {2'b10, 4'b1011}; iReady_AS = 1'b1;
    step();
    iValid_ST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_total++; if (oValid_AS !== 1'b1) $display("FAIL basic_valid%0d: got %b want 1", i, oValid_AS); else n_pass++;
      n_total++; if (oData_AS !== exp_tok[i]) $display("FAIL basic_tok%0d: got %b want %b", i, oData_AS, exp_tok[i]); else n_pass++;
      step();
    end
    n_total++; if (oValid_AS !== 1'b0) $display("FAIL basic_end_valid: got %b want 0", oValid_AS); else n_pass++;
    n_total++; if (oBusy !== 1'b0) $display("FAIL basic_end_busy: got %b want 0", oBusy); else n_pass++;
    n_total++; if (oReady_ST !== 1'b1) $display("FAIL basic_end_ready: got %b want 1", oReady_ST); else n_pass++;
  endtask

  task automatic test_null();
    iValid_ST = 1'b1; iData_ST = {2'b01, 4'b0000}; iReady_AS = 1'b1;
    step();
    iValid_ST = 1'b0;
    n_total++; if (oData_AS !== 6'b11_01_00) $display("FAIL null_tok: got %b want 110100", oData_AS); else n_pass++;
    n_total++; if (oBusy !== 1'b1) $display("FAIL null_busy: got %b want 1", oBusy); else n_pass++;
    step();
    n_total++; if (oBusy !== 1'b0) $display("FAIL null_busy_end: got %b want 0", oBusy); else n_pass++;
    n_total++; if (oValid_AS !== 1'b0) $display("FAIL null_valid_end: got %b want 0", oValid_AS); else n_pass++;
  endtask

  task automatic test_stall();
    iValid_ST = 1'b1; iData_ST = {2'b11, 4'b0110}; iReady_AS = 1'b0;
    step();
    iValid_ST = 1'b0;
    n_total++; if (oData_AS !== 6'b00_11_01) $display("FAIL stall_first: got %b want 001101", oData_AS); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++; if (oData_AS !== 6'b00_11_01) $display("FAIL stall_hold%0d: got %b want 001101", i, oData_AS); else n_pass++;
      n_total++; if (oValid_AS !== 1'b1) $display("FAIL stall_valid%0d: got %b want 1", i, oValid_AS); else n_pass++;
    end
    iReady_AS = 1'b1;
    step();
    n_total++; if (oData_AS !== 6'b01_11_10) $display("FAIL stall_second: got %b want 011110", oData_AS); else n_pass++;
    step();
    n_total++; if (oValid_AS !== 1'b0) $display("FAIL stall_end: got %b want 0", oValid_AS); else n_pass++;
  endtask

  task automatic test_back_to_back();
    iValid_ST = 1'b1; iData_ST = {2'b00, 4'b0011}; iReady_AS = 1'b1;
    step();
    n_total++; if (oReady_ST !== 1'b0) $display("FAIL b2b_ready_run0: got %b want 0", oReady_ST); else n_pass++;
    n_total++; if (oData_AS !== 6'b00_00_00) $display("FAIL b2b_tok0: got %b want 000000", oData_AS); else n_pass++;
    step();
    n_total++; if (oReady_ST !== 1'b0) $display("FAIL b2b_ready_run1: got %b want 0", oReady_ST); else n_pass++;
    n_total++; if (oData_AS !== 6'b01_00_01) $display("FAIL b2b_tok1: got %b want 010001", oData_AS); else n_pass++;
    step();
    n_total++; if (oReady_ST !== 1'b1) $display("FAIL b2b_ready_idle: got %b want 1", oReady_ST); else n_pass++;
    n_total++; if (oBusy !== 1'b0) $display("FAIL b2b_busy_gap: got %b want 0", oBusy); else n_pass++;
    step();
    n_total++; if (oBusy !== 1'b1) $display("FAIL b2b_restart_busy: got %b want 1", oBusy); else n_pass++;
    n_total++; if (oData_AS !== 6'b00_00_00) $display("FAIL b2b_restart_tok: got %b want 000000", oData_AS); else n_pass++;
    iValid_ST = 1'b0;
    repeat (2) step();
    n_total++; if (oBusy !== 1'b0) $display("FAIL b2b_end_busy: got %b want 0", oBusy); else n_pass++;
  endtask

  task automatic test_reset_mid();
    iValid_ST = 1'b1; iData_ST = {2'b01, 4'b0111}; iReady_AS = 1'b1;
    step();
    iValid_ST = 1'b0;
    n_total++; if (oData_AS !== 6'b00_01_00) $display("FAIL rmid_tok0: got %b want 000100", oData_AS); else n_pass++;
    step();
    n_total++; if (oData_AS !== 6'b00_01_01) $display("FAIL rmid_tok1: got %b want 000101", oData_AS); else n_pass++;
    iRST = 1'b1;
    step();
    n_total++; if (oValid_AS !== 1'b0) $display("FAIL rmid_valid: got %b want 0", oValid_AS); else n_pass++;
    n_total++; if (oReady_ST !== 1'b0) $display("FAIL rmid_ready_rst: got %b want 0", oReady_ST); else n_pass++;
    iRST = 1'b0;
    step();
    n_total++; if (oReady_ST !== 1'b1) $display("FAIL rmid_ready_rise: got %b want 1", oReady_ST); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_total++; if (oValid_AS !== 1'b0) $display("FAIL rmid_no_tok%0d: got %b want 0", i, oValid_AS); else n_pass++;
      step();
    end
  endtask

`ifdef SYNSEQ_STATS_EN
  task automatic test_stats();
    iValid_ST = 1'b1; iData_ST = {2'b00, 4'b1111}; iReady_AS = 1'b1;
    step();
    iValid_ST = 1'b0;
    n_total++; if (oTokCnt !== 3'd0) $display("FAIL stats_start: got %0d want 0", oTokCnt); else n_pass++;
    repeat (4) step();
    n_total++; if (oBusy !== 1'b0) $display("FAIL stats_busy_end: got %b want 0", oBusy); else n_pass++;
    n_total++; if (oTokCnt !== 3'd4) $display("FAIL stats_count: got %0d want 4", oTokCnt); else n_pass++;
    iValid_ST = 1'b1; iData_ST = {2'b00, 4'b0001};
    step();
    iValid_ST = 1'b0;
    n_total++; if (oTokCnt !== 3'd0) $display("FAIL stats_clear: got %0d want 0", oTokCnt); else n_pass++;
    step();
    n_total++; if (oTokCnt !== 3'd1) $display("FAIL stats_one: got %0d want 1", oTokCnt); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_null();
    test_stall();
    test_back_to_back();
    test_reset_mid();
`ifdef SYNSEQ_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
